// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO input conditioning stage.
// Optional debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
package gpio_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

  localparam logic INT_LEVEL = 1'b0;
  localparam logic INT_EDGE  = 1'b1;
  localparam logic POL_LOW   = 1'b0;
  localparam logic POL_HIGH  = 1'b1;

  localparam int DB_CYCLES_DEF = 16;

endpackage

// File: rtl/gpio_in_cond_if.sv
// Bus between the SoC GPIO register block and the input conditioning stage.
// fsm_state is a debug view of the settle/run controller.
interface gpio_in_cond_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pins_in;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] int_en;
  logic [WIDTH-1:0] int_type;
  logic [WIDTH-1:0] int_pol;
  logic [WIDTH-1:0] int_clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] int_status;
  logic             irq;
  state_t           fsm_state;

  modport master (
    output pins_in, dir, int_en, int_type, int_pol, int_clr,
    input  data_in, int_status, irq, fsm_state
  );

  modport slave (
    input  pins_in, dir, int_en, int_type, int_pol, int_clr,
    output data_in, int_status, irq, fsm_state
  );
endinterface

// File: rtl/gpio_in_bit.sv
// One GPIO input bit: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// edge detector and interrupt status flop.
module gpio_in_bit
  import gpio_pkg::*;
#(
`ifdef GPIO_DEBOUNCE_EN
  parameter int DB_CYCLES = DB_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic pin,
  input  logic dir,
  input  logic int_en,
  input  logic int_type,
  input  logic int_pol,
  input  logic int_clr,
  output logic data_in,
  output logic int_status
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync2;
  logic                   data_in_d;
  logic                   rise;
  logic                   fall;
  logic                   edge_hit;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign sync2 = sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] db_cnt;

  // During SETTLE the filter is bypassed so data_in starts from the real pin level.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_in <= 1'b0;
      db_cnt  <= '0;
    end else if (!run) begin
      data_in <= sync2;
      db_cnt  <= '0;
    end else if (sync2 == data_in) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
      data_in <= sync2;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) data_in <= 1'b0;
    else       data_in <= sync2;
  end
`endif

  // In SETTLE data_in_d follows the value data_in is loading, so no edge is seen on entry to RUN.
  always_ff @(posedge clk) begin
    if (reset)    data_in_d <= 1'b0;
    else if (run) data_in_d <= data_in;
    else          data_in_d <= sync2;
  end

  assign rise     = data_in & ~data_in_d;
  assign fall     = ~data_in & data_in_d;
  assign edge_hit = (int_pol == POL_HIGH) ? rise : fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_status <= 1'b0;
    end else if (!run || dir || !int_en) begin
      int_status <= 1'b0;
    end else if (int_type == INT_EDGE) begin
      int_status <= (int_status & ~int_clr) | edge_hit;
    end else begin
      int_status <= (data_in == int_pol);
    end
  end

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning top: per-bit conditioners plus shared SETTLE/RUN
// controller and irq OR. Debounce is compiled in with GPIO_DEBOUNCE_EN.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int DB_CYCLES = DB_CYCLES_DEF
`endif
) (
  input  logic          clk,
  input  logic          reset,
  gpio_in_cond_if.slave bus
);
`ifdef GPIO_DEBOUNCE_EN
  localparam int SETTLE_LEN = DB_CYCLES + SYNC_STAGES + 1;
`else
  localparam int SETTLE_LEN = SYNC_STAGES + 1;
`endif
  localparam int             SCW         = $clog2(SETTLE_LEN);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SCW-1:0]   settle_cnt;
  logic             run;
  logic [WIDTH-1:0] data_bits;
  logic [WIDTH-1:0] status_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETTLE && settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == SETTLE && settle_cnt == SETTLE_LAST) state_nxt = RUN;
  end

  always_comb begin
    run = (state == RUN);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_bit
`ifdef GPIO_DEBOUNCE_EN
      #(.DB_CYCLES(DB_CYCLES))
`endif
      u_bit (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pin        (bus.pins_in[i]),
        .dir        (bus.dir[i]),
        .int_en     (bus.int_en[i]),
        .int_type   (bus.int_type[i]),
        .int_pol    (bus.int_pol[i]),
        .int_clr    (bus.int_clr[i]),
        .data_in    (data_bits[i]),
        .int_status (status_bits[i])
      );
  end

  assign bus.data_in    = data_bits;
  assign bus.int_status = status_bits;
  assign bus.irq        = |status_bits;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: directed scenarios plus randomized
// traffic against a behavioural model built from the pin history.
module tb_gpio_in_cond;
  import gpio_pkg::*;

  localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB         = 16;
  localparam int SETTLE_LEN = DB + 3;
  localparam int LAT        = DB + 2;
`else
  localparam int SETTLE_LEN = 3;
  localparam int LAT        = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  gpio_in_cond_if #(.WIDTH(W)) bus ();

  gpio_in_cond #(
    .WIDTH(W)
`ifdef GPIO_DEBOUNCE_EN
    , .DB_CYCLES(DB)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: pin pipeline, conditioned value, previous value, status.
  int           t_since;
  logic [W-1:0] m_s1, m_s2, m_data, m_prev, m_status;
  int           run_len [W];

  task automatic step();
    logic [W-1:0] n_data, n_prev, n_st;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_data = '0; m_prev = '0; m_status = '0; t_since = 0;
      for (int b = 0; b < W; b++) run_len[b] = 0;
    end else begin
      t_since++;
      n_data = m_s2;
      n_prev = m_data;
      n_st   = m_status;
      if (t_since <= SETTLE_LEN) begin
        n_prev = m_s2;
        n_st   = '0;
        for (int b = 0; b < W; b++) run_len[b] = 0;
      end else begin
`ifdef GPIO_DEBOUNCE_EN
        n_data = m_data;
        for (int b = 0; b < W; b++) begin
          if (m_s2[b] != m_data[b]) begin
            run_len[b]++;
            if (run_len[b] == DB) begin
              n_data[b]  = m_s2[b];
              run_len[b] = 0;
            end
          end else begin
            run_len[b] = 0;
          end
        end
`endif
        for (int b = 0; b < W; b++) begin
          logic went_up, went_down;
          went_up   = m_data[b] && !m_prev[b];
          went_down = !m_data[b] && m_prev[b];
          if (bus.dir[b] || !bus.int_en[b])
            n_st[b] = 1'b0;
          else if (bus.int_type[b])
            n_st[b] = (bus.int_pol[b] ? went_up : went_down) || (m_status[b] && !bus.int_clr[b]);
          else
            n_st[b] = (m_data[b] == bus.int_pol[b]);
        end
      end
      m_s2 = m_s1; m_s1 = bus.pins_in;
      m_data = n_data; m_prev = n_prev; m_status = n_st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input logic [W-1:0] d, en, ty, po);
    bus.dir = d; bus.int_en = en; bus.int_type = ty; bus.int_pol = po;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pins_in = 8'hFF; bus.int_clr = '0;
    set_cfg(8'h00, 8'hFF, 8'hFF, 8'hFF);
    steps(3);
    vectors++;
    if (bus.data_in !== 8'h00 || bus.int_status !== 8'h00 || bus.irq !== 1'b0 || bus.fsm_state !== SETTLE) begin
      miscompares++;
      $display("FAIL reset_state: data_in=%h status=%h irq=%b state=%0d, want 00 00 0 SETTLE",
               bus.data_in, bus.int_status, bus.irq, bus.fsm_state);
    end
    reset = 1'b0;
    for (int i = 0; i < SETTLE_LEN + 6; i++) begin
      step();
      vectors++;
      if (bus.data_in !== m_data || bus.int_status !== m_status || bus.irq !== (|m_status)) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d: data_in=%h status=%h irq=%b, want %h %h %b",
                 i, bus.data_in, bus.int_status, bus.irq, m_data, m_status, |m_status);
      end
    end
    vectors++;
    if (bus.data_in !== 8'hFF || bus.int_status !== 8'h00 || bus.fsm_state !== RUN) begin
      miscompares++;
      $display("FAIL settle_no_spurious: data_in=%h status=%h state=%0d, want FF 00 RUN",
               bus.data_in, bus.int_status, bus.fsm_state);
    end
  endtask

  task automatic test_edge_rise();
    bus.pins_in = 8'h00;
    set_cfg(8'h00, 8'h01, 8'h01, 8'h01);
    steps(LAT + 4);
    bus.pins_in[0] = 1'b1;
    steps(LAT - 1);
    vectors++;
    if (bus.data_in[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_latency_early: data_in[0]=%b, want 0", bus.data_in[0]);
    end
    step();
    vectors++;
    if (bus.data_in[0] !== 1'b1 || bus.int_status[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_data: data_in[0]=%b status[0]=%b, want 1 0", bus.data_in[0], bus.int_status[0]);
    end
    step();
    vectors++;
    if (bus.int_status !== 8'h01 || bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rise_status: status=%h irq=%b, want 01 1", bus.int_status, bus.irq);
    end
    bus.int_clr = 8'h01;
    step();
    bus.int_clr = 8'h00;
    vectors++;
    if (bus.int_status !== 8'h00 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_clear: status=%h irq=%b, want 00 0", bus.int_status, bus.irq);
    end
  endtask

  task automatic test_level_low();
    set_cfg(8'h00, 8'h20, 8'h00, 8'h00);
    steps(2);
    vectors++;
    if (bus.int_status !== 8'h20) begin
      miscompares++;
      $display("FAIL level_active: status=%h, want 20", bus.int_status);
    end
    bus.int_clr = 8'h20;
    step();
    bus.int_clr = 8'h00;
    vectors++;
    if (bus.int_status !== 8'h20) begin
      miscompares++;
      $display("FAIL level_clr_ignored: status=%h, want 20", bus.int_status);
    end
    bus.pins_in[5] = 1'b1;
    steps(LAT);
    vectors++;
    if (bus.int_status !== 8'h20) begin
      miscompares++;
      $display("FAIL level_hold: status=%h, want 20", bus.int_status);
    end
    step();
    vectors++;
    if (bus.int_status !== 8'h00) begin
      miscompares++;
      $display("FAIL level_release: status=%h, want 00", bus.int_status);
    end
  endtask

  task automatic test_clr_collision();
    set_cfg(8'h00, 8'h04, 8'h04, 8'h00);
    bus.pins_in[2] = 1'b1;
    steps(LAT + 2);
    bus.pins_in[2] = 1'b0;
    steps(LAT + 1);
    vectors++;
    if (bus.int_status !== 8'h04) begin
      miscompares++;
      $display("FAIL fall_status: status=%h, want 04", bus.int_status);
    end
    bus.pins_in[2] = 1'b1;
    steps(LAT + 2);
    bus.pins_in[2] = 1'b0;
    steps(LAT);
    bus.int_clr = 8'h04;
    step();
    bus.int_clr = 8'h00;
    vectors++;
    if (bus.int_status !== 8'h04) begin
      miscompares++;
      $display("FAIL set_beats_clear: status=%h, want 04", bus.int_status);
    end
    bus.int_clr = 8'h04;
    step();
    bus.int_clr = 8'h00;
    vectors++;
    if (bus.int_status !== 8'h00) begin
      miscompares++;
      $display("FAIL fall_clear: status=%h, want 00", bus.int_status);
    end
  endtask

  task automatic test_dir_mask();
    bus.pins_in = 8'h00;
    set_cfg(8'h0F, 8'hFF, 8'hFF, 8'hFF);
    steps(LAT + 4);
    bus.pins_in = 8'hFF;
    steps(LAT + 1);
    vectors++;
    if (bus.int_status !== 8'hF0 || bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL dir_mask: status=%h irq=%b, want F0 1", bus.int_status, bus.irq);
    end
    bus.int_en = 8'h00;
    step();
    vectors++;
    if (bus.int_status !== 8'h00 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_drops: status=%h irq=%b, want 00 0", bus.int_status, bus.irq);
    end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    int n;
    bus.pins_in = 8'h00;
    set_cfg(8'h00, 8'h08, 8'h08, 8'h08);
    steps(LAT + 4);
    bus.pins_in[3] = 1'b1;
    steps(10);
    bus.pins_in[3] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      vectors++;
      if (bus.data_in[3] !== 1'b0 || bus.int_status[3] !== 1'b0) begin
        miscompares++;
        $display("FAIL short_pulse cyc %0d: data_in[3]=%b status[3]=%b, want 0 0",
                 i, bus.data_in[3], bus.int_status[3]);
      end
    end
    bus.pins_in[3] = 1'b1;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.data_in[3] === 1'b1) break;
    end
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL long_pulse_latency: rose after %0d cycles, want 18", n);
    end
    steps(2);
    bus.pins_in[3] = 1'b0;
    steps(LAT + 2);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0)
        set_cfg(W'($urandom & $urandom), W'($urandom), W'($urandom), W'($urandom));
`ifdef GPIO_DEBOUNCE_EN
      if ($urandom_range(0, 5) == 0) bus.pins_in = bus.pins_in ^ W'($urandom & $urandom);
`else
      bus.pins_in = bus.pins_in ^ W'($urandom & $urandom);
`endif
      bus.int_clr = W'($urandom & $urandom);
      step();
      vectors++;
      if (bus.data_in !== m_data || bus.int_status !== m_status || bus.irq !== (|m_status)) begin
        miscompares++;
        $display("FAIL random cyc %0d: data_in=%h status=%h irq=%b, want %h %h %b",
                 i, bus.data_in, bus.int_status, bus.irq, m_data, m_status, |m_status);
      end
    end
    bus.int_clr = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.pins_in = '0; bus.int_clr = '0;
    set_cfg('0, '0, '0, '0);
    test_reset();
    test_edge_rise();
    test_level_low();
    test_clr_collision();
    test_dir_mask();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
Input conditioning stage directly downstream of the GPIO pad bidirectional control.
- Takes raw pad readback (from_pin) and performs 2-flop synchronisation, optional debounce, and edge/level interrupt detection.
- Presents a clean data_in bus plus sticky interrupt status and a single irq line to the SoC GPIO register block.

Parameters:
WIDTH, 8, number of GPIO bits.
DB_CYCLES, 16, debounce stability window in clk cycles; legal range 2..65535; counter width CW = $clog2(DB_CYCLES+1).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
pins_in  in  WIDTH  raw pad readback, asynchronous to clk.
dir  in  WIDTH  1 = bit driven as output; interrupts are suppressed on that bit.
int_en  in  WIDTH  per-bit interrupt enable.
int_type  in  WIDTH  0 = level, 1 = edge.
int_pol  in  WIDTH  level: 1 = active-high, 0 = active-low; edge: 1 = rising, 0 = falling.
int_clr  in  WIDTH  one-cycle write-1-to-clear pulse for edge status.
data_in  out  WIDTH  conditioned input value.
int_status  out  WIDTH  per-bit interrupt status.
irq  out  1  OR of int_status.

Behaviour:
- Reset state: sync1/sync2 = 0; data_in = 0; data_in_d = 0; debounce counters = 0; int_status = 0; irq = 0; FSM = SETTLE with settle counter = 0.
- Synchroniser:
  - sync1 <= pins_in; sync2 <= sync1.
  - Without debounce: data_in <= sync2.
  - Latency: a pin change set up before edge N appears on data_in after edge N+2.
- FSM has two states, SETTLE and RUN.
  - SETTLE lasts 3 cycles, or DB_CYCLES+3 cycles when debounce is compiled in.
  - In SETTLE, data_in loads sync2 directly, bypassing the debounce filter.
  - In SETTLE, int_status is held at 0, edge detection is disabled, and data_in_d tracks data_in.
  - SETTLE -> RUN when the settle counter reaches its terminal value. RUN persists until reset.
  - Reset asserted in any state returns to SETTLE next edge. This prevents a pin held high through reset from raising a spurious rising edge.
- Edge detect in RUN:
  - data_in_d <= data_in.
  - rise = data_in & ~data_in_d; fall = ~data_in & data_in_d.
  - edge_hit = int_pol ? rise : fall.
- Status per bit, evaluated when dir = 0 and int_en = 1:
  - Edge type: status <= (status & ~int_clr) | edge_hit. If set and clear occur in the same cycle, set wins.
  - Edge status is registered one cycle after data_in changes.
  - Level type: status <= (data_in == int_pol). Non-sticky; int_clr is ignored.
- If dir = 1 or int_en = 0: status <= 0 next cycle. A pending edge is lost.
- Changing int_type or int_pol mid-operation takes effect next cycle. Existing edge status persists until cleared or until the bit is disabled.
- irq = |int_status, combinational from registers and glitch-free.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: a per-bit counter operates in RUN.
  - If sync2 == data_in, the counter is cleared.
  - Otherwise it increments. When it reaches DB_CYCLES-1 and sync2 still differs, data_in <= sync2 and the counter is cleared.
  - Pulses shorter than DB_CYCLES cycles at sync2 never reach data_in.
  - Latency: pin change to data_in is 2+DB_CYCLES cycles.
- Undefined: no counters; data_in <= sync2; DB_CYCLES is unused.

Decomposition:
- Package gpio_pkg holds:
  - SETTLE/RUN state encoding.
  - SYNC_STAGES = 2.
  - INT_LEVEL/INT_EDGE and POL_LOW/POL_HIGH constants.
  - DB_CYCLES default.
- Sub-module gpio_in_bit contains a single bit's synchroniser, debounce counter, edge detect and status flop. It is instanced WIDTH times in a generate loop.
- The top level holds the shared SETTLE/RUN FSM and settle counter, broadcasting a run flag, plus the irq OR.

Test Plan:
- Reset with pins_in = 8'hFF, then release -> data_in = 8'hFF after the SETTLE period; int_status stays 8'h00 with all bits edge/rising/enabled.
- No debounce, bit0 edge/rising enabled, pins_in[0] 0->1 before edge N -> data_in[0] = 1 after N+2; int_status[0] = 1 and irq = 1 after N+3; int_clr[0] pulse clears status next cycle.
- Debounce, DB_CYCLES = 16:
  - 10-cycle high pulse on pins_in[3] -> data_in[3] stays 0 and no status.
  - 20-cycle pulse -> data_in[3] rises 18 cycles after the pin edge.
- Bit5 level active-low enabled, pins_in[5] = 0 -> status[5] = 1 continuously; int_clr[5] has no effect; pin -> 1 gives status 0 three cycles later.
- int_clr[2] coincident with a new falling edge on bit2 (edge/falling) -> status[2] remains 1.
- dir = 8'h0F, all edges enabled, toggle pins_in = 8'hFF -> int_status = 8'hF0 only; setting int_en = 0 mid-pending clears status next cycle.
